// File: rtl/uarc_pkg.sv
// Shared types and sizing for the UARC bus channel: channel FSM states, FIFO entry layout,
// and word-width derivation.
package uarc_pkg;

    localparam int unsigned UARC_WORD_MAG  = 5;
    localparam int unsigned UARC_DEPTH_MAG = 2;

    function automatic int unsigned uarc_word_width(input int unsigned mag);
        return 32'(1) << mag;
    endfunction

    localparam int unsigned UARC_WORD_WIDTH = uarc_word_width(UARC_WORD_MAG);

    typedef enum logic [1:0] {
        StIdle,
        StKillFwd,
        StKillDone
    } uarc_state_e;

    // Entry layout at the default word width; the stream-disabled build drops is_stream.
    typedef struct packed {
        logic                       is_stream;
        logic [UARC_WORD_WIDTH-1:0] data;
    } uarc_entry_t;

endpackage

// File: rtl/uarc_bus_channel_if.sv
// Sender/receiver signal bundle of one UARC bus channel. The slave modport is the channel's
// view; master is the environment (sender core plus receiver core).
interface uarc_bus_channel_if
    import uarc_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = UARC_WORD_WIDTH
);
    logic                  enable;
    logic                  kill;
    logic                  send;
    logic                  stream;
    logic [WORD_WIDTH-1:0] data;
    logic                  kill_ack;
    logic                  send_ack;
    logic                  stream_ack;

    logic                  recv_kill;
    logic                  recv_send;
    logic                  recv_stream;
    logic [WORD_WIDTH-1:0] recv_data;
    logic                  recv_kill_ack;
    logic                  recv_send_ack;
    logic                  recv_stream_ack;

    modport slave (
        input  enable, kill, send, stream, data,
        input  recv_kill_ack, recv_send_ack, recv_stream_ack,
        output kill_ack, send_ack, stream_ack,
        output recv_kill, recv_send, recv_stream, recv_data
    );

    modport master (
        output enable, kill, send, stream, data,
        output recv_kill_ack, recv_send_ack, recv_stream_ack,
        input  kill_ack, send_ack, stream_ack,
        input  recv_kill, recv_send, recv_stream, recv_data
    );
endinterface

// File: rtl/uarc_fifo.sv
// Synchronous FIFO with occupancy counter, flush, and a registered-count full/empty view.
// Refused pushes (full) and pops (empty) are dropped; flush wins over both.
module uarc_fifo #(
    parameter int unsigned Width    = 33,
    parameter int unsigned DepthMag = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [Width-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [Width-1:0] head
);
    localparam int unsigned       Depth     = 1 << DepthMag;
    localparam logic [DepthMag:0] FullCount = (DepthMag + 1)'(Depth);

    logic [DepthMag-1:0] wr_ptr_q, wr_ptr_d;
    logic [DepthMag-1:0] rd_ptr_q, rd_ptr_d;
    logic [DepthMag:0]   count_q, count_d;
    logic [Width-1:0]    mem_q [Depth];
    logic                do_push, do_pop;

    assign full    = (count_q == FullCount);
    assign empty   = (count_q == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an empty FIFO never exposes its head.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uarc_bus_channel.sv
// Buffered point-to-point UARC bus channel: sender handshakes, FIFO, kill flush-and-ack FSM.
// Define UARC_STREAM_EN to build the stream path; otherwise only single-word sends are carried.
module uarc_bus_channel
    import uarc_pkg::*;
#(
    parameter int unsigned WORD_MAG  = UARC_WORD_MAG,
    parameter int unsigned DEPTH_MAG = UARC_DEPTH_MAG
) (
    input logic               clk,
    input logic               reset,
    uarc_bus_channel_if.slave bus
);
    localparam int unsigned WORD_WIDTH = uarc_word_width(WORD_MAG);
`ifdef UARC_STREAM_EN
    localparam int unsigned ENTRY_W = WORD_WIDTH + 1;
`else
    localparam int unsigned ENTRY_W = WORD_WIDTH;
`endif

    uarc_state_e        state_q, state_d;
    logic               send_ack_q, send_ack_d;
    logic               idle, sender_on;
    logic               send_take, stream_take;
    logic               push, pop, flush;
    logic               full, empty;
    logic               head_is_stream;
    logic [ENTRY_W-1:0] wr_entry, head;

    assign idle      = (state_q == StIdle);
    assign sender_on = idle && bus.enable;
    // send_ack_q blocks a second push while the sender still holds send during its ack cycle.
    assign send_take = sender_on && !bus.kill && bus.send && !full && !send_ack_q;

`ifdef UARC_STREAM_EN
    // stream_ack is combinational, so it is held low while reset is asserted.
    assign stream_take    = reset && sender_on && !bus.kill && !bus.send && bus.stream && !full;
    assign wr_entry       = {stream_take, bus.data};
    assign head_is_stream = head[ENTRY_W-1];
`else
    logic unused_stream;
    assign unused_stream  = bus.stream;
    assign stream_take    = 1'b0;
    assign wr_entry       = bus.data;
    assign head_is_stream = 1'b0;
`endif

    assign push  = send_take || stream_take;
    assign flush = sender_on && bus.kill;
    assign pop   = (bus.recv_send && bus.recv_send_ack) ||
                   (bus.recv_stream && bus.recv_stream_ack);

    uarc_fifo #(
        .Width    (ENTRY_W),
        .DepthMag (DEPTH_MAG)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wr_entry),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    always_comb begin
        state_d    = state_q;
        send_ack_d = send_take;
        unique case (state_q)
            StIdle:     if (bus.enable && bus.kill) state_d = StKillFwd;
            StKillFwd:  if (bus.recv_kill_ack) state_d = StKillDone;
            StKillDone: state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            send_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            send_ack_q <= send_ack_d;
        end
    end

    assign bus.send_ack    = send_ack_q;
    assign bus.stream_ack  = stream_take;
    assign bus.kill_ack    = (state_q == StKillDone);
    assign bus.recv_kill   = (state_q == StKillFwd);
    assign bus.recv_send   = idle && !empty && !head_is_stream;
    assign bus.recv_stream = idle && !empty && head_is_stream;
    assign bus.recv_data   = empty ? '0 : head[WORD_WIDTH-1:0];

endmodule

// File: tb/tb_uarc_bus_channel.sv
// Scoreboard bench for uarc_bus_channel: directed stimulus queues expected words, a negedge
// monitor checks every receiver pop. Stream cases are built only with UARC_STREAM_EN.
module tb_uarc_bus_channel;

    typedef struct packed {
        logic        is_stream;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    uarc_bus_channel_if #(.WORD_WIDTH(32)) bus ();

    uarc_bus_channel #(
        .WORD_MAG  (5),
        .DEPTH_MAG (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic is_stream, input logic [31:0] d);
        exp_t e;
        e.is_stream = is_stream;
        e.data      = d;
        exp_q.push_back(e);
    endtask

    task automatic clear_inputs();
        bus.kill            = 1'b0;
        bus.send            = 1'b0;
        bus.stream          = 1'b0;
        bus.data            = '0;
        bus.recv_kill_ack   = 1'b0;
        bus.recv_send_ack   = 1'b0;
        bus.recv_stream_ack = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_kill_ack"},    32'(bus.kill_ack), 0);
        check({tag, "_send_ack"},    32'(bus.send_ack), 0);
        check({tag, "_stream_ack"},  32'(bus.stream_ack), 0);
        check({tag, "_recv_kill"},   32'(bus.recv_kill), 0);
        check({tag, "_recv_send"},   32'(bus.recv_send), 0);
        check({tag, "_recv_stream"}, 32'(bus.recv_stream), 0);
        check({tag, "_recv_data"},   bus.recv_data, 0);
    endtask

    // Single send from an idle sender: ack must follow one cycle after issue.
    task automatic send_word(input logic [31:0] d);
        bus.send = 1'b1;
        bus.data = d;
        expect_word(1'b0, d);
        step();
        check("send_ack", 32'(bus.send_ack), 1);
        bus.send = 1'b0;
        step();
        check("send_ack_pulse", 32'(bus.send_ack), 0);
    endtask

    task automatic drain_send(input int n);
        bus.recv_send_ack = 1'b1;
        repeat (n) step();
        bus.recv_send_ack = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 &&
            ((bus.recv_send && bus.recv_send_ack) || (bus.recv_stream && bus.recv_stream_ack))) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL pop_unexpected: got word %0h, required no word", bus.recv_data);
            end else begin
                e = exp_q.pop_front();
                check("pop_data", bus.recv_data, e.data);
                check("pop_kind", 32'(bus.recv_stream), 32'(e.is_stream));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b0;
        bus.enable = 1'b0;
        clear_inputs();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset      = 1'b1;
        bus.enable = 1'b1;
        step();

        // Send into empty FIFO, visible in the ack cycle, popped by receiver.
        bus.send = 1'b1;
        bus.data = 32'hDEAD_BEEF;
        expect_word(1'b0, 32'hDEAD_BEEF);
        step();
        check("t1_send_ack", 32'(bus.send_ack), 1);
        check("t1_recv_send", 32'(bus.recv_send), 1);
        check("t1_recv_data", bus.recv_data, 32'hDEAD_BEEF);
        bus.send = 1'b0;
        step();
        check("t1_send_ack_pulse", 32'(bus.send_ack), 0);
        check("t1_recv_send_held", 32'(bus.recv_send), 1);
        drain_send(1);
        check("t1_recv_send_gone", 32'(bus.recv_send), 0);
        check("t1_recv_data_zero", bus.recv_data, 0);

`ifdef UARC_STREAM_EN
        // Six stream words into a 4-deep FIFO with no receiver ack.
        for (int k = 1; k <= 6; k++) begin
            bus.stream = 1'b1;
            bus.data   = 32'(k);
            #1;
            check("t2_stream_ack", 32'(bus.stream_ack), (k <= 4) ? 1 : 0);
            if (k <= 4) expect_word(1'b1, 32'(k));
            step();
        end
        bus.stream = 1'b0;
        #1;
        check("t2_recv_stream", 32'(bus.recv_stream), 1);
        check("t2_recv_send", 32'(bus.recv_send), 0);
        check("t2_head", bus.recv_data, 1);
        // Full with simultaneous pop: push refused that cycle, accepted the next.
        bus.stream          = 1'b1;
        bus.data            = 32'd7;
        bus.recv_stream_ack = 1'b1;
        #1;
        check("t3_stream_ack_full", 32'(bus.stream_ack), 0);
        step();
        bus.recv_stream_ack = 1'b0;
        #1;
        check("t3_stream_ack_after_pop", 32'(bus.stream_ack), 1);
        expect_word(1'b1, 32'd7);
        step();
        bus.stream = 1'b0;
        bus.recv_stream_ack = 1'b1;
        repeat (4) step();
        bus.recv_stream_ack = 1'b0;
        check("t3_drained", 32'(bus.recv_stream), 0);
        // Mismatched ack is ignored.
        bus.stream = 1'b1;
        bus.data   = 32'h33;
        expect_word(1'b1, 32'h33);
        step();
        bus.stream        = 1'b0;
        bus.recv_send_ack = 1'b1;
        step();
        bus.recv_send_ack = 1'b0;
        check("t3_mismatch_held", 32'(bus.recv_stream), 1);
        bus.recv_stream_ack = 1'b1;
        step();
        bus.recv_stream_ack = 1'b0;
`else
        // Stream path absent: stream and recv_stream_ack have no effect.
        bus.stream          = 1'b1;
        bus.data            = 32'h55;
        bus.recv_stream_ack = 1'b1;
        #1;
        check("t2_stream_ack_off", 32'(bus.stream_ack), 0);
        step();
        step();
        check("t2_recv_stream_off", 32'(bus.recv_stream), 0);
        check("t2_no_enqueue", 32'(bus.recv_send), 0);
        bus.stream          = 1'b0;
        bus.recv_stream_ack = 1'b0;
`endif

        // Fill with sends, then push/pop at full.
        for (int k = 0; k < 4; k++) send_word(32'hA0 + 32'(k));
        bus.send = 1'b1;
        bus.data = 32'hBB;
        step();
        check("t3_send_refused_full", 32'(bus.send_ack), 0);
        bus.recv_send_ack = 1'b1;
        step();
        bus.recv_send_ack = 1'b0;
        check("t3_send_refused_pop", 32'(bus.send_ack), 0);
        expect_word(1'b0, 32'hBB);
        step();
        check("t3_send_after_pop", 32'(bus.send_ack), 1);
        bus.send = 1'b0;
        drain_send(4);
        check("t3_send_drained", 32'(bus.recv_send), 0);

        // Kill with three buffered words.
        for (int k = 0; k < 3; k++) send_word(32'hC0 + 32'(k));
        bus.kill = 1'b1;
        step();
        exp_q.delete();
        check("t4_recv_kill", 32'(bus.recv_kill), 1);
        check("t4_recv_send_masked", 32'(bus.recv_send), 0);
        check("t4_recv_stream_masked", 32'(bus.recv_stream), 0);
        check("t4_kill_ack_early", 32'(bus.kill_ack), 0);
        step();
        step();
        check("t4_kill_ack_wait", 32'(bus.kill_ack), 0);
        bus.recv_kill_ack = 1'b1;
        step();
        check("t4_kill_ack", 32'(bus.kill_ack), 1);
        check("t4_recv_kill_off", 32'(bus.recv_kill), 0);
        bus.kill          = 1'b0;
        bus.recv_kill_ack = 1'b0;
        step();
        check("t4_kill_ack_pulse", 32'(bus.kill_ack), 0);
        check("t4_flushed", 32'(bus.recv_send), 0);
        check("t4_flushed_data", bus.recv_data, 0);

        // Kill and send together: kill wins, nothing enqueued.
        bus.kill = 1'b1;
        bus.send = 1'b1;
        bus.data = 32'h77;
        step();
        check("t5_no_send_ack", 32'(bus.send_ack), 0);
        check("t5_recv_kill", 32'(bus.recv_kill), 1);
        bus.recv_kill_ack = 1'b1;
        step();
        check("t5_kill_ack", 32'(bus.kill_ack), 1);
        check("t5_no_send_ack2", 32'(bus.send_ack), 0);
        clear_inputs();
        step();
        check("t5_no_enqueue", 32'(bus.recv_send), 0);

        // Sender ignored while enable is low.
        bus.enable = 1'b0;
        bus.send   = 1'b1;
        bus.data   = 32'h99;
        step();
        check("t6_disabled_send", 32'(bus.send_ack), 0);
        bus.send = 1'b0;
        bus.kill = 1'b1;
        step();
        check("t6_disabled_kill", 32'(bus.recv_kill), 0);
        check("t6_disabled_enqueue", 32'(bus.recv_send), 0);
        bus.kill   = 1'b0;
        bus.enable = 1'b1;

        // Asynchronous reset with two buffered words and the sender still active.
`ifdef UARC_STREAM_EN
        bus.stream = 1'b1;
        bus.data   = 32'h21;
        step();
        bus.data = 32'h22;
        step();
        bus.data = 32'h23;
`else
        send_word(32'h21);
        send_word(32'h22);
        exp_q.delete();
        bus.send = 1'b1;
        bus.data = 32'h23;
        step();
`endif
        #2;
        reset = 1'b0;
        #1;
        exp_q.delete();
        check_all_zero("t7_async");
        clear_inputs();
        @(negedge clk);
        reset = 1'b1;
        step();
        check("t7_empty_send", 32'(bus.recv_send), 0);
        check("t7_empty_stream", 32'(bus.recv_stream), 0);
        check("t7_idle", 32'(bus.recv_kill), 0);
        send_word(32'h1234_5678);
        check("t7_post_reset_head", bus.recv_data, 32'h1234_5678);
        drain_send(1);

        step();
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uarc_bus_channel.md
# uarc_bus_channel

Buffered point-to-point UARC bus channel between one sender core and one receiver core. It sits directly downstream of a core's global send/stream/kill outputs and its per-bus `sender_enables` bit. It sits upstream of the receiving core's `receiver_*` inputs. A small FIFO decouples sender from receiver, and kill requests are forwarded with a flush-and-acknowledge handshake.

## Interface
- WORD_MAG, 5, log2 of word width; WORD_WIDTH = 1 << WORD_MAG
- DEPTH_MAG, 2, log2 of FIFO depth; DEPTH = 1 << DEPTH_MAG
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- enable  in  1  this channel selected by the sender (its `sender_enables` bit)
- kill  in  1  sender kill request, level, held until kill_ack
- send  in  1  sender single-word send, level, held until send_ack
- stream  in  1  sender stream word valid
- data  in  WORD_WIDTH  sender word
- kill_ack  out  1  one-cycle pulse: kill completed
- send_ack  out  1  one-cycle pulse: send word enqueued
- stream_ack  out  1  stream word accepted this cycle
- recv_kill  out  1  kill forwarded to receiver
- recv_send  out  1  FIFO head is a send word
- recv_stream  out  1  FIFO head is a stream word
- recv_data  out  WORD_WIDTH  FIFO head data
- recv_kill_ack  in  1  receiver accepted kill
- recv_send_ack  in  1  receiver pops send head this cycle
- recv_stream_ack  in  1  receiver pops stream head this cycle

## Operation
- FIFO entry is {is_stream, data}. Occupancy counter ranges 0..DEPTH. Read and write pointers are DEPTH_MAG bits and wrap modulo DEPTH.
- full = (count == DEPTH); empty = (count == 0). Both are derived from registered count only.
- State machine IDLE, KILL_FWD, KILL_DONE.
- IDLE:
  - enable && kill -> KILL_FWD. Nothing is accepted that cycle.
  - Otherwise, enable && send && !full && !send_ack -> push {0,data}; send_ack=1 next cycle.
  - Otherwise, enable && stream && !full -> stream_ack=1 combinationally and push {1,data} at the edge.
  - send has priority over stream. While send is asserted, stream_ack=0.
- KILL_FWD:
  - recv_kill=1. FIFO is flushed (count, pointers cleared) on entry.
  - recv_send=0 and recv_stream=0; no pushes.
  - recv_kill_ack -> KILL_DONE.
- KILL_DONE:
  - kill_ack=1 for exactly one cycle, then -> IDLE.
  - A sender still holding kill in IDLE restarts a new kill.
- Receiver side, state IDLE only:
  - recv_send = !empty && !head.is_stream.
  - recv_stream = !empty && head.is_stream.
  - recv_data = head data, or 0 when empty.
  - A pop occurs when the matching ack is high with the matching valid. A mismatched ack is ignored.
- Push and pop in the same cycle: count unchanged, both pointers advance. A push is still refused when the registered value is full.
- enable low: the sender side is ignored entirely. Receiver draining continues.

## Timing
- Reset values:
  - state=IDLE, count=0, pointers=0.
  - kill_ack, send_ack, stream_ack, recv_kill, recv_send, recv_stream = 0.
  - recv_data = 0.
- Send latency: accept edge -> send_ack high the following cycle. The word is visible at recv_* in that same cycle if the FIFO was empty.
- Stream throughput: one word per cycle while not full.
- Kill latency: kill seen -> recv_kill next cycle -> kill_ack one cycle after recv_kill_ack.
- Reset asserted mid-kill or mid-stream: immediate return to reset values; buffered words are lost.

## Configuration
- UARC_STREAM_EN defined: stream path as described.
- UARC_STREAM_EN undefined:
  - stream and recv_stream_ack are ignored.
  - stream_ack=0 and recv_stream=0.
  - FIFO entries omit is_stream.
  - Sends are unaffected.

## Structure
- Shared package uarc_pkg holds:
  - channel state enum (IDLE, KILL_FWD, KILL_DONE);
  - FIFO entry struct typedef;
  - WORD_WIDTH derivation from WORD_MAG.
- Sub-module uarc_fifo: parameterized-width synchronous FIFO with push, pop, flush, full, empty and head ports. The channel FSM and handshakes live in uarc_bus_channel.

## Test plan
- Send, empty FIFO: enable=1, send=1, data=0xDEADBEEF -> send_ack pulse next cycle; recv_send=1, recv_data=0xDEADBEEF; recv_send_ack -> recv_send=0.
- Stream fill, DEPTH=4: 6 consecutive stream words 1..6 with no receiver ack -> stream_ack high for 4 cycles then low; full; draining yields 1,2,3,4.
- Simultaneous push/pop at full: count=4, stream=1 and recv_stream_ack=1 -> no push that cycle; count becomes 3.
- Kill with 3 buffered words -> recv_kill next cycle and recv_send/recv_stream=0. recv_kill_ack after 2 cycles -> single kill_ack pulse; FIFO empty.
- kill and send asserted together in IDLE -> kill path taken, no send_ack, no enqueue.
- reset driven low mid-stream with count=2 -> all outputs 0 asynchronously; after release, empty and IDLE.
